// File: rtl/wdf_pkg.sv
// Shared definitions for the wave-digital-filter adaptor sequencer.
//   DW_DEF / CW_DEF : default sample and coefficient widths
//   seq_state_e     : sequencer FSM encoding (IDLE / RUN / OUT)
//   clog2           : elaboration-time ceiling log2 for index widths
package wdf_pkg;

    localparam int DW_DEF = 12;
    localparam int CW_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } seq_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/wdf_sec_regfile.sv
// Per-section register file: NSEC delay states (DW) and NSEC coefficients (CW).
//   clk_i, rst_ni        : clock, asynchronous active-low reset (clears both fields)
//   clr_i                : synchronous clear of the states only; coefficients survive
//   st_we_i/addr/data    : state write port
//   cf_we_i/addr/data    : coefficient write port
//   rd_addr_i            : asynchronous read index for both fields
//   st_o, cf_o           : state and coefficient at rd_addr_i
import wdf_pkg::*;

module wdf_sec_regfile #(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int NSEC = 4,
    parameter int AW   = clog2(NSEC)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          st_we_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [DW-1:0] st_data_i,
    input  logic          cf_we_i,
    input  logic [AW-1:0] cf_addr_i,
    input  logic [CW-1:0] cf_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] st_o,
    output logic [CW-1:0] cf_o
);

    logic [DW-1:0] st_q [NSEC];
    logic [CW-1:0] cf_q [NSEC];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSEC; i++) st_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < NSEC; i++) st_q[i] <= '0;
        end else if (st_we_i) begin
            st_q[st_addr_i] <= st_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSEC; i++) cf_q[i] <= '0;
        end else if (cf_we_i) begin
            cf_q[cf_addr_i] <= cf_data_i;
        end
    end

    assign st_o = st_q[rd_addr_i];
    assign cf_o = cf_q[rd_addr_i];

endmodule

// File: rtl/wdf_adaptor_seq.sv
// Time-multiplexed sequencer sharing one external two-port adaptor across NSEC
// cascaded first-order allpass sections. Each accepted sample walks sections
// 0..NSEC-1 (one per cycle), then is presented on the output until taken.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous clear of states, x register and FSM
//   in_vld/in_rdy/in_data: sample input handshake
//   out_vld/out_rdy/out_data : filtered sample output handshake
//   cfg_we/cfg_addr/cfg_data/cfg_rdy : coefficient write port (IDLE only)
//   ad_a1/ad_a2/ad_alpha : to shared adaptor (zero outside RUN)
//   ad_b1/ad_b2          : from shared adaptor (forward output, next state)
//   busy                 : FSM not in IDLE
import wdf_pkg::*;

module wdf_adaptor_seq #(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int NSEC = 4,
    parameter int AW   = clog2(NSEC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_rdy,
    output logic [DW-1:0] ad_a1,
    output logic [DW-1:0] ad_a2,
    output logic [CW-1:0] ad_alpha,
    input  logic [DW-1:0] ad_b1,
    input  logic [DW-1:0] ad_b2,
    output logic          busy
);

    localparam logic [AW-1:0] K_LAST = AW'(NSEC - 1);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [DW-1:0] x_q, x_d;
    logic          st_we;
    logic          cf_we;
    logic          cfg_addr_ok;
    logic [DW-1:0] st_rd;
    logic [CW-1:0] cf_rd;

    // When NSEC fills the address space every address is a real section.
    generate
        if (NSEC == (1 << AW)) begin : g_addr_full
            assign cfg_addr_ok = 1'b1;
        end else begin : g_addr_partial
            assign cfg_addr_ok = (cfg_addr < K_LAST) || (cfg_addr == K_LAST);
        end
    endgenerate

    // clr outranks a coefficient write landing on the same edge.
    assign cf_we = cfg_we && (state_q == ST_IDLE) && !clr && cfg_addr_ok;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        st_we   = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            k_d     = '0;
            x_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_vld) begin
                        x_d     = in_data;
                        k_d     = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Forward result becomes next section's input; b2 is the new delay state.
                    x_d   = ad_b1;
                    st_we = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_OUT;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_rdy) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
        end
    end

    wdf_sec_regfile #(
        .DW   (DW),
        .CW   (CW),
        .NSEC (NSEC),
        .AW   (AW)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (clr),
        .st_we_i   (st_we),
        .st_addr_i (k_q),
        .st_data_i (ad_b2),
        .cf_we_i   (cf_we),
        .cf_addr_i (cfg_addr),
        .cf_data_i (cfg_data),
        .rd_addr_i (k_q),
        .st_o      (st_rd),
        .cf_o      (cf_rd)
    );

    assign in_rdy   = (state_q == ST_IDLE);
    assign cfg_rdy  = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign out_vld  = (state_q == ST_OUT);
    assign out_data = (state_q == ST_OUT) ? x_q : '0;

    // Adaptor ports come only from registered state, never from in_*.
    assign ad_a1    = (state_q == ST_RUN) ? x_q   : '0;
    assign ad_a2    = (state_q == ST_RUN) ? st_rd : '0;
    assign ad_alpha = (state_q == ST_RUN) ? cf_rd : '0;

endmodule
